// File: rtl/shift_pkg.sv
// Shared definitions for the shift/bit-manipulation units: FSM encoding and
// count-width helper.
package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A count of 0..dw inclusive needs one bit more than the index width.
  function automatic int cnt_width(input int dw);
    return $clog2(dw) + 1;
  endfunction

endpackage

// File: rtl/shift_lzc_step.sv
// Combinational priority encoder over one STEP-bit slice: position of the
// leading one counted from the MSB, plus an all-zero flag.
module shift_lzc_step #(
  parameter int STEP = 4,
  parameter int LZW  = (STEP > 1) ? $clog2(STEP) : 1
) (
  input  logic [STEP-1:0] bits,
  output logic [LZW-1:0]  lz,
  output logic            all_zero
);

  logic found;

  // NOTE: every variable written here gets a default first, so no path
  // through the loop can leave it unassigned and infer a latch.
  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = STEP - 1; i >= 0; i--) begin
      if (!found && bits[i]) begin
        lz    = LZW'(STEP - 1 - i);
        found = 1'b1;
      end
    end
  end

  assign all_zero = ~|bits;

endmodule

// File: rtl/shift_norm_iter.sv
// Iterative left-normalizer: shifts a word left STEP bits per cycle until the
// leading one reaches the MSB and reports the shift (count-leading-zeros).
module shift_norm_iter
  import shift_pkg::*;
#(
  parameter int DW   = 32,
  parameter int STEP = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic [cnt_width(DW)-1:0] out_cnt,
  output logic                     out_zero
);

  localparam int CW  = cnt_width(DW);
  localparam int LZW = (STEP > 1) ? $clog2(STEP) : 1;

  state_t          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            zero_q, zero_d;

  logic [STEP-1:0] top_bits;
  logic [LZW-1:0]  lz;
  logic            all_zero;

  assign top_bits = data_q[DW-1 -: STEP];

  shift_lzc_step #(
    .STEP (STEP),
    .LZW  (LZW)
  ) u_lzc (
    .bits     (top_bits),
    .lz       (lz),
    .all_zero (all_zero)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;

    // Abort takes priority over acceptance, handshake and iteration alike.
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            cnt_d = '0;
            if (in_data == '0) begin
              state_d = ST_DONE;
              data_d  = '0;
              cnt_d   = CW'(DW);
              zero_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
              data_d  = in_data;
              zero_d  = 1'b0;
            end
          end
        end

        ST_RUN: begin
          if (all_zero) begin
            data_d = data_q << STEP;
            cnt_d  = cnt_q + CW'(STEP);
          end else begin
            data_d  = data_q << lz;
            cnt_d   = cnt_q + CW'(lz);
            state_d = ST_DONE;
          end
        end

        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

  // Intermediate shift state is not exposed while iterating.
  assign out_data = out_valid ? data_q : '0;
  assign out_cnt  = out_valid ? cnt_q  : '0;
  assign out_zero = out_valid ? zero_q : 1'b0;

endmodule

// File: tb/tb_shift_norm_iter.sv
// Directed and randomized checks of shift_norm_iter (DW=32, STEP=4).
module tb_shift_norm_iter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [5:0]    out_cnt;
  logic          out_zero;

  int total  = 0;
  int passed = 0;

  shift_norm_iter #(.DW(32), .STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
  endtask

  function automatic int ref_clz(input logic [31:0] d);
    for (int i = 31; i >= 0; i--) if (d[i]) return 31 - i;
    return 32;
  endfunction

  // Present one request and count edges after the accepting edge until
  // out_valid is seen; in_data is scrambled afterwards to prove it is not re-sampled.
  task automatic issue(input logic [31:0] d, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~d;
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] d, input int exp_cnt,
                        input logic [31:0] exp_data, input logic exp_zero, input int exp_lat);
    int lat;
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    issue(d, lat);
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".out_cnt"}, 64'(out_cnt), 64'(exp_cnt));
    check({tag, ".out_data"}, 64'(out_data), 64'(exp_data));
    check({tag, ".out_zero"}, 64'(out_zero), 64'(exp_zero));
  endtask

  initial begin
    int lat;
    logic [31:0] d;
    logic [31:0] held_data;
    logic [5:0]  held_cnt;
    int k;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.in_ready",  64'(in_ready),  64'd1);
    check("rst.out_data",  64'(out_data),  64'd0);
    check("rst.out_cnt",   64'(out_cnt),   64'd0);
    check("rst.out_zero",  64'(out_zero),  64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Latency counts edges after the accepting edge: floor(clz/4)+1.
    run_op("one", 32'h0000_0001, 31, 32'h8000_0000, 1'b0, 8);
    release_out();
    check("one.in_ready_after", 64'(in_ready), 64'd1);

    run_op("msb", 32'h8000_0000, 0, 32'h8000_0000, 1'b0, 1);
    release_out();
    run_op("mid", 32'h0001_2345, 15, 32'h91A2_8000, 1'b0, 4);
    release_out();
    // Zero input goes straight to DONE on the accepting edge itself.
    run_op("zero", 32'h0000_0000, 32, 32'h0000_0000, 1'b1, 0);
    release_out();

    // Backpressure: result held for 5 cycles.
    run_op("bp", 32'h0000_0F00, 20, 32'hF000_0000, 1'b0, 6);
    held_data = out_data;
    held_cnt  = out_cnt;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.out_valid", 64'(out_valid), 64'd1);
      check("bp.in_ready",  64'(in_ready),  64'd0);
      check("bp.out_data",  64'(out_data),  64'(held_data));
      check("bp.out_cnt",   64'(out_cnt),   64'(held_cnt));
    end
    release_out();
    check("bp.in_ready_release", 64'(in_ready), 64'd1);
    check("bp.out_valid_release", 64'(out_valid), 64'd0);
    run_op("b2b", 32'h0000_8000, 16, 32'h8000_0000, 1'b0, 5);
    release_out();

    // Flush in the second RUN cycle discards the operation.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h0000_0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_run.in_ready",  64'(in_ready),  64'd1);
    check("flush_run.out_valid", 64'(out_valid), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    check("flush_run.no_result", 64'(out_valid), 64'd0);
    run_op("after_flush", 32'h00F0_0000, 8, 32'hF000_0000, 1'b0, 3);
    release_out();

    // Flush in IDLE blocks a simultaneous request.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h0000_0010;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("flush_idle.out_valid", 64'(out_valid), 64'd0);

    // Flush while a result waits in DONE drops it.
    run_op("pre_flush_done", 32'h0400_0000, 5, 32'h8000_0000, 1'b0, 2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_done.out_valid", 64'(out_valid), 64'd0);
    check("flush_done.in_ready",  64'(in_ready),  64'd1);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h0000_0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.in_ready",  64'(in_ready),  64'd1);
    check("arst.out_valid", 64'(out_valid), 64'd0);
    check("arst.out_cnt",   64'(out_cnt),   64'd0);
    check("arst.out_data",  64'(out_data),  64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("arst.still_idle", 64'(out_valid), 64'd0);
    run_op("post_rst", 32'h0000_0100, 23, 32'h8000_0000, 1'b0, 6);
    release_out();

    // Random scoreboard with a spread of leading-zero counts.
    for (int n = 0; n < 3000; n++) begin
      d = $urandom() >> $urandom_range(0, 32);
      k = ref_clz(d);
      issue(d, lat);
      check("rand", {18'd0, 7'(lat), out_zero, out_cnt, out_data},
            {18'd0, 7'((d == 0) ? 0 : (k / 4 + 1)), (d == 32'd0), 6'(k), d << k});
      release_out();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
